// File: rtl/sprite_blitter.sv
// Rectangle blitter: walks a request row-major, reads a latency-L sprite ROM (or fills),
// clips to the screen, applies the colour key and streams plot/x/y/color to the VGA adapter.
module sprite_blitter #(
    parameter int                 WIDTH_X        = 9,
    parameter int                 WIDTH_Y        = 9,
    parameter int                 SCREEN_X       = 320,
    parameter int                 SCREEN_Y       = 240,
    parameter int                 SIZE_W         = 7,
    parameter int                 ADDR_W         = 16,
    parameter int                 COLOR_W        = 3,
    parameter int                 MEM_LATENCY    = 1,
    parameter int                 TRANSPARENT_EN = 1,
    parameter logic [COLOR_W-1:0] TRANSPARENT    = 3'b101
) (
    input  logic               clk,
    input  logic               resetn,
    input  logic               req_valid,
    output logic               req_ready,
    input  logic [WIDTH_X-1:0] req_x0,
    input  logic [WIDTH_Y-1:0] req_y0,
    input  logic [SIZE_W-1:0]  req_w,
    input  logic [SIZE_W-1:0]  req_h,
    input  logic               req_fill,
    input  logic [COLOR_W-1:0] req_color,
    input  logic [ADDR_W-1:0]  req_base,
    output logic               rom_rd,
    output logic [ADDR_W-1:0]  rom_addr,
    input  logic [COLOR_W-1:0] rom_data,
    output logic               plot,
    output logic [WIDTH_X-1:0] x,
    output logic [WIDTH_Y-1:0] y,
    output logic [COLOR_W-1:0] color,
    output logic               busy,
    output logic               done
);

    typedef enum logic [1:0] {S_IDLE, S_SCAN, S_DRAIN} state_t;

    localparam int                DW       = $clog2(MEM_LATENCY + 1);
    localparam int                LS       = MEM_LATENCY - 1;
    localparam logic [DW-1:0]     LP_DLAST = DW'(MEM_LATENCY);
    localparam logic [WIDTH_X:0]  LP_SX    = (WIDTH_X+1)'(SCREEN_X);
    localparam logic [WIDTH_Y:0]  LP_SY    = (WIDTH_Y+1)'(SCREEN_Y);

    state_t               r_state, w_state_nx;
    logic [WIDTH_X-1:0]   r_x0;
    logic [WIDTH_Y-1:0]   r_y0;
    logic [SIZE_W-1:0]    r_w, r_h, r_cx, r_cy;
    logic                 r_fill;
    logic [COLOR_W-1:0]   r_fcol;
    logic [ADDR_W-1:0]    r_acc;
    logic [DW-1:0]        r_dcnt, w_dcnt_nx;
    logic                 r_done, r_plot;
    logic [WIDTH_X-1:0]   r_x;
    logic [WIDTH_Y-1:0]   r_y;
    logic [COLOR_W-1:0]   r_color;

    logic                 r_vld_p  [MEM_LATENCY];
    logic [WIDTH_X-1:0]   r_sx_p   [MEM_LATENCY];
    logic [WIDTH_Y-1:0]   r_sy_p   [MEM_LATENCY];
    logic                 r_inb_p  [MEM_LATENCY];
    logic                 r_fill_p [MEM_LATENCY];
    logic [COLOR_W-1:0]   r_fcol_p [MEM_LATENCY];

    logic                 w_accept, w_empty, w_row_end, w_last;
    logic [WIDTH_X:0]     w_sx;
    logic [WIDTH_Y:0]     w_sy;
    logic                 w_inb;

    function automatic logic f_visible(input logic inb, input logic fill,
                                       input logic [COLOR_W-1:0] pix);
        return inb && (fill || (TRANSPARENT_EN == 0) || (pix != TRANSPARENT));
    endfunction

    assign w_accept  = req_valid && req_ready;
    assign w_empty   = (req_w == '0) || (req_h == '0);
    assign w_row_end = (r_cx == r_w - SIZE_W'(1));
    assign w_last    = w_row_end && (r_cy == r_h - SIZE_W'(1));
    // Extra top bit keeps coordinates past the screen edge from wrapping back into view
    assign w_sx      = {1'b0, r_x0} + (WIDTH_X+1)'(r_cx);
    assign w_sy      = {1'b0, r_y0} + (WIDTH_Y+1)'(r_cy);
    assign w_inb     = (w_sx < LP_SX) && (w_sy < LP_SY);

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) r_state <= S_IDLE;
        else         r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx = r_state;
        case (r_state)
            S_IDLE:  if (w_accept) w_state_nx = w_empty ? S_DRAIN : S_SCAN;
            S_SCAN:  if (w_last) w_state_nx = S_DRAIN;
            S_DRAIN: if (r_dcnt == LP_DLAST) w_state_nx = S_IDLE;
            default: w_state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        req_ready = (r_state == S_IDLE);
        busy      = (r_state != S_IDLE);
        rom_rd    = (r_state == S_SCAN) && !r_fill;
        rom_addr  = (r_state == S_SCAN) ? r_acc : '0;
    end

    // Empty requests enter DRAIN already at the last count so done follows acceptance directly
    always_comb begin
        w_dcnt_nx = r_dcnt;
        case (r_state)
            S_IDLE:  w_dcnt_nx = LP_DLAST;
            S_SCAN:  w_dcnt_nx = '0;
            S_DRAIN: w_dcnt_nx = r_dcnt + DW'(1);
            default: w_dcnt_nx = '0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (w_accept) begin
            r_x0   <= req_x0;
            r_y0   <= req_y0;
            r_w    <= req_w;
            r_h    <= req_h;
            r_fill <= req_fill;
            r_fcol <= req_color;
            r_acc  <= req_base;
            r_cx   <= '0;
            r_cy   <= '0;
        end else if (r_state == S_SCAN) begin
            r_acc <= r_acc + ADDR_W'(1);
            if (w_row_end) begin
                r_cx <= '0;
                r_cy <= r_cy + SIZE_W'(1);
            end else begin
                r_cx <= r_cx + SIZE_W'(1);
            end
        end
    end

    // Pixel stage 0 .. MEM_LATENCY-1: attributes travel alongside the outstanding ROM read
    always_ff @(posedge clk) begin
        r_sx_p[0]   <= w_sx[WIDTH_X-1:0];
        r_sy_p[0]   <= w_sy[WIDTH_Y-1:0];
        r_inb_p[0]  <= w_inb;
        r_fill_p[0] <= r_fill;
        r_fcol_p[0] <= r_fcol;
        for (int i = 1; i < MEM_LATENCY; i++) begin
            r_sx_p[i]   <= r_sx_p[i-1];
            r_sy_p[i]   <= r_sy_p[i-1];
            r_inb_p[i]  <= r_inb_p[i-1];
            r_fill_p[i] <= r_fill_p[i-1];
            r_fcol_p[i] <= r_fcol_p[i-1];
        end
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            r_dcnt  <= '0;
            r_done  <= 1'b0;
            r_plot  <= 1'b0;
            r_x     <= '0;
            r_y     <= '0;
            r_color <= '0;
            for (int i = 0; i < MEM_LATENCY; i++) r_vld_p[i] <= 1'b0;
        end else begin
            r_dcnt     <= w_dcnt_nx;
            r_done     <= (w_state_nx == S_DRAIN) && (w_dcnt_nx == LP_DLAST);
            r_vld_p[0] <= (r_state == S_SCAN);
            for (int i = 1; i < MEM_LATENCY; i++) r_vld_p[i] <= r_vld_p[i-1];
            // Output stage: ROM data lines up with the last pipeline stage
            if (r_vld_p[LS]) begin
                r_plot  <= f_visible(r_inb_p[LS], r_fill_p[LS], rom_data);
                r_x     <= r_sx_p[LS];
                r_y     <= r_sy_p[LS];
                r_color <= r_fill_p[LS] ? r_fcol_p[LS] : rom_data;
            end else begin
                r_plot <= 1'b0;
            end
        end
    end

    assign plot  = r_plot;
    assign x     = r_x;
    assign y     = r_y;
    assign color = r_color;
    assign done  = r_done;

endmodule

// File: tb/tb_sprite_blitter.sv
// Bench for sprite_blitter: two instances (ROM latency 1 and 3), a session monitor and a
// pixel-list reference model computed from each accepted request.
module tb_sprite_blitter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        resetn;
    logic        rv;
    bit          sel;
    logic [8:0]  rx0, ry0;
    logic [6:0]  rw, rh;
    logic        rfill;
    logic [2:0]  rcol;
    logic [15:0] rbase;

    logic        ready_a, rd_a, plot_a, busy_a, done_a;
    logic [15:0] addr_a;
    logic [2:0]  data_a, color_a;
    logic [8:0]  x_a, y_a;
    logic        ready_b, rd_b, plot_b, busy_b, done_b;
    logic [15:0] addr_b;
    logic [2:0]  data_b, color_b;
    logic [8:0]  x_b, y_b;

    logic [2:0]  rom_mem [65536];
    logic [2:0]  pipe_b  [3];

    always @(posedge clk) begin
        data_a    <= rom_mem[addr_a];
        pipe_b[0] <= rom_mem[addr_b];
        pipe_b[1] <= pipe_b[0];
        pipe_b[2] <= pipe_b[1];
    end
    assign data_b = pipe_b[2];

    sprite_blitter #(.MEM_LATENCY(1)) u_a (
        .clk(clk), .resetn(resetn), .req_valid(rv && !sel), .req_ready(ready_a),
        .req_x0(rx0), .req_y0(ry0), .req_w(rw), .req_h(rh), .req_fill(rfill),
        .req_color(rcol), .req_base(rbase), .rom_rd(rd_a), .rom_addr(addr_a),
        .rom_data(data_a), .plot(plot_a), .x(x_a), .y(y_a), .color(color_a),
        .busy(busy_a), .done(done_a));

    sprite_blitter #(.MEM_LATENCY(3)) u_b (
        .clk(clk), .resetn(resetn), .req_valid(rv && sel), .req_ready(ready_b),
        .req_x0(rx0), .req_y0(ry0), .req_w(rw), .req_h(rh), .req_fill(rfill),
        .req_color(rcol), .req_base(rbase), .rom_rd(rd_b), .rom_addr(addr_b),
        .rom_data(data_b), .plot(plot_b), .x(x_b), .y(y_b), .color(color_b),
        .busy(busy_b), .done(done_b));

    wire        w_ready = sel ? ready_b : ready_a;
    wire        w_rd    = sel ? rd_b    : rd_a;
    wire        w_plot  = sel ? plot_b  : plot_a;
    wire        w_done  = sel ? done_b  : done_a;
    wire [15:0] w_addr  = sel ? addr_b  : addr_a;
    wire [8:0]  w_x     = sel ? x_b     : x_a;
    wire [8:0]  w_y     = sel ? y_b     : y_a;
    wire [2:0]  w_col   = sel ? color_b : color_a;

    typedef struct {
        int cyc; int x0; int y0; int w; int h; int fill; int col; int base;
    } acc_t;
    typedef struct { int cyc; int a; int b; int c; } ev_t;
    typedef struct {
        int sel; int x0; int y0; int w; int h; int fill; int col; int base;
        longint keymask; int exp_plots; int exp_done;
    } vec_t;

    int   cyc = 0;
    int   n_tests = 0;
    int   n_fail = 0;
    bit   mon_en = 1'b0;
    acc_t acc_q[$];
    ev_t  plot_q[$];
    ev_t  rom_q[$];
    int   done_q[$];
    vec_t vecs[12];

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (mon_en) begin
            if (rv && w_ready)
                acc_q.push_back(acc_t'{cyc, int'(rx0), int'(ry0), int'(rw), int'(rh),
                                       int'(rfill), int'(rcol), int'(rbase)});
            if (w_rd)   rom_q.push_back(ev_t'{cyc, int'(w_addr), 0, 0});
            if (w_plot) plot_q.push_back(ev_t'{cyc, int'(w_x), int'(w_y), int'(w_col)});
            if (w_done) done_q.push_back(cyc);
        end
    end

    task automatic chk(input string name, input int act, input int exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic chk_ev(input string name, input ev_t a, input ev_t e);
        n_tests++;
        if (a.cyc != e.cyc || a.a != e.a || a.b != e.b || a.c != e.c) begin
            n_fail++;
            $display("FAIL %s: got cyc=%0d (%0d,%0d,%0d) expected cyc=%0d (%0d,%0d,%0d)",
                     name, a.cyc, a.a, a.b, a.c, e.cyc, e.a, e.b, e.c);
        end
    endtask

    task automatic wait_accept();
        bit acc, ok;
        ok = 1'b0;
        for (int k = 0; k < 600; k++) begin
            acc = w_ready;
            @(posedge clk); #1;
            if (acc) begin ok = 1'b1; break; end
        end
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic set_req(input int x0, input int y0, input int w, input int h,
                           input int fill, input int col, input int base);
        rx0 = 9'(x0); ry0 = 9'(y0); rw = 7'(w); rh = 7'(h);
        rfill = 1'(fill); rcol = 3'(col); rbase = 16'(base);
    endtask

    task automatic send(input int x0, input int y0, input int w, input int h,
                        input int fill, input int col, input int base);
        @(posedge clk); #1;
        set_req(x0, y0, w, h, fill, col, base);
        rv = 1'b1;
        wait_accept();
        rv = 1'b0;
    endtask

    task automatic begin_session(input bit s);
        @(posedge clk); #1;
        sel = s;
        acc_q.delete(); plot_q.delete(); rom_q.delete(); done_q.delete();
        mon_en = 1'b1;
    endtask

    task automatic load_rom(input int base, input int n, input longint km);
        for (int i = 0; i < n; i++)
            rom_mem[(base + i) & 65535] = (i < 64 && km[i]) ? 3'd5 : 3'(i % 4);
    endtask

    // Reference: every accepted request expands into its address list, visible pixels and done
    task automatic check_session(input string tag);
        ev_t ep[$], er[$];
        int  ed[$];
        int  lat, prev_ready, n, addr, sx, sy, c;
        lat = sel ? 3 : 1;
        prev_ready = -1;
        foreach (acc_q[i]) begin
            n = acc_q[i].w * acc_q[i].h;
            if (i > 0)
                chk($sformatf("%s_accept_after_ready%0d", tag, i),
                    int'(acc_q[i].cyc >= prev_ready), 1);
            for (int k = 0; k < n; k++) begin
                addr = (acc_q[i].base + k) & 65535;
                sx = acc_q[i].x0 + k % acc_q[i].w;
                sy = acc_q[i].y0 + k / acc_q[i].w;
                if (acc_q[i].fill == 0) er.push_back(ev_t'{acc_q[i].cyc + 1 + k, addr, 0, 0});
                c = (acc_q[i].fill != 0) ? acc_q[i].col : int'(rom_mem[addr]);
                if (sx < 320 && sy < 240 && (acc_q[i].fill != 0 || c != 5))
                    ep.push_back(ev_t'{acc_q[i].cyc + 2 + k + lat, sx, sy, c});
            end
            ed.push_back(n == 0 ? acc_q[i].cyc + 1 : acc_q[i].cyc + 1 + n + lat);
            prev_ready = (n == 0) ? acc_q[i].cyc + 2 : acc_q[i].cyc + n + lat + 2;
        end
        chk({tag, "_nplot"}, plot_q.size(), ep.size());
        chk({tag, "_nrom"}, rom_q.size(), er.size());
        chk({tag, "_ndone"}, done_q.size(), ed.size());
        for (int i = 0; i < ep.size() && i < plot_q.size(); i++)
            chk_ev($sformatf("%s_plot%0d", tag, i), plot_q[i], ep[i]);
        for (int i = 0; i < er.size() && i < rom_q.size(); i++)
            chk_ev($sformatf("%s_rom%0d", tag, i), rom_q[i], er[i]);
        for (int i = 0; i < ed.size() && i < done_q.size(); i++)
            chk($sformatf("%s_done%0d", tag, i), done_q[i], ed[i]);
    endtask

    task automatic end_session(input string tag);
        bit idle;
        idle = 1'b0;
        for (int k = 0; k < 600; k++) begin
            @(negedge clk);
            if (w_ready) begin idle = 1'b1; break; end
        end
        if (!idle) chk({tag, "_idle_timeout"}, 0, 1);
        repeat (2) @(negedge clk);
        @(posedge clk); #1;
        mon_en = 1'b0;
        check_session(tag);
    endtask

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        resetn = 1'b0; rv = 1'b0; sel = 1'b0;
        set_req(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 65536; i++) rom_mem[i] = 3'($urandom % 8);

        //           sel x0  y0  w   h  fill col base  keymask  plots done
        vecs[0]  = '{0, 10, 20, 4,  2, 0, 0, 100,   64'h00, 8,   10};
        vecs[1]  = '{0, 10, 20, 4,  2, 0, 0, 100,   64'h42, 6,   10};
        vecs[2]  = '{0, 318, 238, 3, 3, 1, 2, 0,    64'h00, 4,   11};
        vecs[3]  = '{0, 10, 20, 0,  5, 0, 0, 50,    64'h00, 0,   1};
        vecs[4]  = '{1, 10, 20, 4,  2, 0, 0, 100,   64'h00, 8,   12};
        vecs[5]  = '{1, 318, 238, 3, 3, 1, 2, 0,    64'h00, 4,   13};
        vecs[6]  = '{1, 5,  5,  3,  0, 0, 0, 70,    64'h00, 0,   1};
        vecs[7]  = '{0, 319, 0, 2,  2, 0, 0, 300,   64'h00, 2,   6};
        vecs[8]  = '{0, 0,  239, 127, 1, 0, 0, 1000, 64'h00, 127, 129};
        vecs[9]  = '{1, 316, 237, 6, 4, 1, 7, 0,    64'h00, 12,  28};
        vecs[10] = '{1, 10, 20, 4,  2, 0, 0, 100,   64'h42, 6,   12};
        vecs[11] = '{0, 0,  0,  1,  1, 0, 0, 65535, 64'h01, 0,   3};

        #12;
        chk("rst_plot_a", int'(plot_a), 0);
        chk("rst_done_a", int'(done_a), 0);
        chk("rst_xy_a", int'({x_a, y_a}), 0);
        chk("rst_color_a", int'(color_a), 0);
        chk("rst_rom_a", int'({rd_a, addr_a}), 0);
        chk("rst_ready_a", int'(ready_a), 1);
        chk("rst_busy_b", int'(busy_b), 0);
        chk("rst_plot_b", int'(plot_b), 0);
        @(posedge clk); #1;
        resetn = 1'b1;

        foreach (vecs[i]) begin
            if (vecs[i].fill == 0) load_rom(vecs[i].base, vecs[i].w * vecs[i].h, vecs[i].keymask);
            begin_session(vecs[i].sel != 0);
            send(vecs[i].x0, vecs[i].y0, vecs[i].w, vecs[i].h, vecs[i].fill, vecs[i].col,
                 vecs[i].base);
            end_session($sformatf("vec%0d", i));
            chk($sformatf("vec%0d_plots", i), plot_q.size(), vecs[i].exp_plots);
            if (done_q.size() > 0 && acc_q.size() > 0)
                chk($sformatf("vec%0d_done_off", i), done_q[0] - acc_q[0].cyc, vecs[i].exp_done);
        end

        // Back-to-back 2x1 requests with req_valid held high, both latencies
        for (int s = 0; s < 2; s++) begin
            load_rom(200, 2, 64'h0);
            begin_session(s != 0);
            set_req(5, 5, 2, 1, 1, 3, 0);
            rv = 1'b1;
            wait_accept();
            set_req(50, 60, 2, 1, 0, 0, 200);
            wait_accept();
            rv = 1'b0;
            end_session($sformatf("b2b%0d", s));
            chk($sformatf("b2b%0d_naccept", s), acc_q.size(), 2);
            chk($sformatf("b2b%0d_nplot", s), plot_q.size(), 4);
            if (acc_q.size() == 2)
                chk($sformatf("b2b%0d_gap", s), acc_q[1].cyc - acc_q[0].cyc, (s != 0) ? 7 : 5);
        end

        // Reset pulse mid-SCAN of an 8x8 sprite
        load_rom(500, 64, 64'h0);
        begin_session(0);
        send(40, 40, 8, 8, 0, 0, 500);
        repeat (10) @(posedge clk);
        #1;
        chk("midscan_busy", int'(busy_a), 1);
        resetn = 1'b0;
        #1;
        chk("arst_plot", int'(plot_a), 0);
        chk("arst_done", int'(done_a), 0);
        chk("arst_rom_rd", int'(rd_a), 0);
        chk("arst_rom_addr", int'(addr_a), 0);
        chk("arst_xy", int'({x_a, y_a}), 0);
        chk("arst_color", int'(color_a), 0);
        chk("arst_ready", int'(ready_a), 1);
        @(posedge clk); #1;
        resetn = 1'b1;
        plot_q.delete(); rom_q.delete(); done_q.delete();
        repeat (20) @(posedge clk);
        #1;
        mon_en = 1'b0;
        chk("post_rst_no_done", done_q.size(), 0);
        chk("post_rst_no_plot", plot_q.size(), 0);
        chk("post_rst_no_rd", rom_q.size(), 0);
        chk("post_rst_ready", int'(ready_a), 1);
        begin_session(0);
        send(100, 100, 2, 2, 1, 6, 0);
        end_session("post_rst_req");
        chk("post_rst_req_plots", plot_q.size(), 4);

        // Randomised sessions of 1..3 requests against the reference model
        for (int r = 0; r < 30; r++) begin
            int nreq;
            nreq = 1 + $urandom % 3;
            begin_session(1'($urandom % 2));
            for (int q = 0; q < nreq; q++) begin
                repeat ($urandom % 3) @(posedge clk);
                send($urandom % 330, $urandom % 250, $urandom % 9, $urandom % 9,
                     $urandom % 2, $urandom % 8, $urandom % 65536);
            end
            end_session($sformatf("rnd%0d", r));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/sprite_blitter.md
# sprite_blitter

Parametrised rectangle blitter that replaces the fixed per-sprite plotter instances in the datapath. It accepts one draw request at a time over a valid/ready handshake: screen origin, size, and either a sprite ROM base address or a solid fill colour. It walks the rectangle row-major, reads an external synchronous sprite ROM with configurable latency, and emits plot/x/y/color straight into the VGA adapter. New over the fixed plotters: runtime size and origin, transparency colour-key, screen-edge clipping, fill mode, and a done pulse aligned to the last pixel.

## Interface
- WIDTH_X, 9, screen x coordinate width
- WIDTH_Y, 9, screen y coordinate width
- SCREEN_X, 320, visible width; pixels with x ≥ SCREEN_X are clipped
- SCREEN_Y, 240, visible height; pixels with y ≥ SCREEN_Y are clipped
- SIZE_W, 7, width of req_w/req_h (max sprite edge 127)
- ADDR_W, 16, sprite ROM address width
- COLOR_W, 3, colour width
- MEM_LATENCY, 1, ROM read latency in cycles (≥1)
- TRANSPARENT_EN, 1, enable colour-key skip for ROM pixels
- TRANSPARENT, 3'b101, key colour
- clk  in  1  system clock (CLOCK_50)
- resetn  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block idle; request accepted when req_valid && req_ready at a rising edge
- req_x0  in  WIDTH_X  top-left x
- req_y0  in  WIDTH_Y  top-left y
- req_w, req_h  in  SIZE_W  rectangle size in pixels
- req_fill  in  1  1 = solid fill with req_color, no ROM reads
- req_color  in  COLOR_W  fill colour
- req_base  in  ADDR_W  ROM address of sprite pixel (0,0)
- rom_rd  out  1  ROM address valid this cycle
- rom_addr  out  ADDR_W  ROM address
- rom_data  in  COLOR_W  ROM colour, valid MEM_LATENCY cycles after rom_rd
- plot  out  1  write pixel to VGA adapter
- x  out  WIDTH_X  pixel x
- y  out  WIDTH_Y  pixel y
- color  out  COLOR_W  pixel colour
- busy  out  1  request in progress (!req_ready)
- done  out  1  one-cycle pulse, request complete

## Operation
- States: IDLE, SCAN, DRAIN.
- IDLE: req_ready=1. On accept, latch all req_* fields and clear cx, cy and the address accumulator (set to req_base). Go to SCAN; go to DRAIN if req_w==0 or req_h==0.
- SCAN: emit one pixel per cycle; cx increments 0..w-1, then wraps to 0 and cy increments; rom_addr = accumulator, incremented by 1 per pixel (no multiplier). rom_rd = !fill. After pixel (w-1,h-1) is issued, go to DRAIN.
- Pipeline: a MEM_LATENCY-deep shift register carries {valid, sx, sy, inb, fill, fcol}.
  - sx = x0+cx and sy = y0+cy, computed at WIDTH+1 bits.
  - inb = (sx<SCREEN_X) && (sy<SCREEN_Y). No wrap-around: clipped pixels are dropped, never folded.
- Output register, captured when the pipeline's last stage is valid:
  - color = fill ? fcol : rom_data.
  - plot = inb && (fill || !TRANSPARENT_EN || rom_data!=TRANSPARENT).
  - x, y = low bits of sx, sy.
  - When the stage is not valid, plot=0 and x, y, color hold their values.
- DRAIN: count MEM_LATENCY+1 cycles, then return to IDLE. done is high in the last DRAIN cycle, which coincides with the output cycle of the final pixel. For an empty request, done is high in the single DRAIN cycle following acceptance.
- req_valid is ignored while busy. Request inputs may change after acceptance.
- Reset, asynchronous and at any time, including mid-SCAN: state=IDLE, pipeline valids=0, plot=0, done=0, rom_rd=0, x=y=color=0, rom_addr=0. The request in flight is discarded and no done is issued.

## Timing
- Accept at edge T. Pixel n (0-based, row-major) has its address presented in cycle T+1+n. plot/x/y/color for pixel n are valid in cycle T+2+n+MEM_LATENCY.
- A W×H request (N = W·H) occupies N+MEM_LATENCY+2 cycles from acceptance to req_ready returning high. done is high in cycle T+1+N+MEM_LATENCY; req_ready is high the following cycle.
- Throughput: one pixel per cycle, with no bubbles across row boundaries.
- All outputs are registered except req_ready and busy (decoded from state) and rom_rd/rom_addr (decoded from state and counters).

## Test plan
- 4×2 ROM sprite at (10,20), base 100, MEM_LATENCY=1, ROM returns addr[2:0] -> rom_addr sequence 100..107; plot high 8 consecutive cycles with (x,y) = (10,20)…(13,20),(10,21)…(13,21); done aligned with the (13,21) cycle.
- Same request, but ROM returns 3'b101 at addresses 101 and 106 -> plot low for (11,20) and (12,21); x/y sequence and done timing unchanged.
- Fill request 3×3 at (318,238), colour 3'b010 -> rom_rd never high; plot only for (318,238),(319,238),(318,239),(319,239); done after 9 pixel slots.
- req_w=0 -> no rom_rd, no plot, done one cycle after accept, req_ready high the next cycle.
- Two back-to-back 2×1 requests with req_valid held high -> second accepted the cycle req_ready rises; no pixel lost or duplicated; repeat with MEM_LATENCY=3 and check alignment.
- Assert resetn=0 for one cycle mid-SCAN of an 8×8 sprite -> outputs zero immediately; no done; block idle and accepts a new request after release.
